apb_timer_slave: RTL and testbench
==================================

# apb_timer_slave

APB completer that implements a programmable down-counting timer with a four-register map, configurable wait states and error response. It is the peripheral-side counterpart of the team's APB master: it sits on that master's timer select line and answers its SETUP/ACCESS transfers with PREADY, PRDATA and PSLVERR. It raises a level interrupt on expiry.

## Interface
- ADDR_WIDTH, 32, PADDR width; only PADDR[7:0] is decoded.
- DATA_WIDTH, 32, data and register width; must be ≥ 3.
- WAIT_STATES, 1, number of PREADY-low access cycles before completion; 0 means zero-wait. Range 0–15.

Ports:
- PCLK  in  1  sole clock; all flops are on the rising edge.
- PRESETn  in  1  reset; asynchronous, active-low.
- PSEL  in  1  select from the master's timer select line.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PRDATA  out  DATA_WIDTH  read data; valid only while PREADY=1 on a read; 0 otherwise.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error; valid only while PREADY=1.
- irq  out  1  STATUS.EXPIRED & CTRL.IRQ_EN.

## Operation
- Register map (PADDR[7:0]):
  - 0x00 CTRL (RW): bit 0 EN, bit 1 AUTO_RELOAD, bit 2 IRQ_EN.
  - 0x04 LOAD (RW).
  - 0x08 COUNT (RO).
  - 0x0C STATUS (bit 0 EXPIRED, write-1-to-clear).
  - Unused bits read 0.
- Decode errors:
  - PSLVERR=1 when PADDR[1:0]≠0, PADDR[7:4]≠0, or there is a write to COUNT.
  - An erroring transfer has no register side effect and returns PRDATA=0.
- Handshake FSM:
  - IDLE: on PSEL & !PENABLE, go to SETUP and load wcnt=WAIT_STATES.
  - SETUP: go to ACCESS next cycle.
  - ACCESS:
    - If PSEL & PENABLE and wcnt≠0: decrement wcnt and hold PREADY=0.
    - If wcnt=0: PREADY=1, commit, go to IDLE.
  - PSEL low in SETUP or ACCESS: abort to IDLE with no commit, PREADY stays 0.
- Commit:
  - A write updates the register at the PCLK edge ending the PREADY=1 cycle.
  - A read samples the register value present in the PREADY=1 cycle.
- Timer core:
  - While EN=1 and COUNT≠0, COUNT decrements by 1 per cycle.
  - When EN=1 and COUNT=0:
    - EXPIRED is set.
    - If AUTO_RELOAD=1, COUNT is loaded from LOAD.
    - If AUTO_RELOAD=0, EN is cleared (one-shot).
  - A LOAD write also loads COUNT with PWDATA.
  - EN=0 freezes COUNT.
- Simultaneous events:
  - Hardware set of EXPIRED beats W1C in the same cycle.
  - A LOAD write beats decrement or reload.
  - A CTRL write beats the one-shot EN clear.
- LOAD=0 with EN and AUTO_RELOAD set: EXPIRED is re-set every cycle.
- Counter arithmetic is modulo 2^DATA_WIDTH, but COUNT never decrements below 0.

## Timing
- Reset values: PRDATA=0, PREADY=0, PSLVERR=0, irq=0, CTRL=LOAD=COUNT=STATUS=0, FSM=IDLE, wcnt=0.
- Reset asserted mid-transfer returns everything to reset values immediately. The transfer is lost.
- Transfer length is 2+WAIT_STATES cycles: setup T0, PREADY=1 in cycle T1+WAIT_STATES.
- PREADY, PSLVERR and PRDATA are combinational from FSM state, wcnt and registers. There is no combinational path from PWDATA to PRDATA.
- Back-to-back transfers: ACCESS completes, then the next cycle has PSEL=1, PENABLE=0, which the block accepts from IDLE with no idle gap.
- irq rises the cycle after COUNT reaches 0 with EN set. It falls the cycle after a W1C or an IRQ_EN clear.

## Structure
- Package apb_timer_pkg holds:
  - register offset constants;
  - CTRL/STATUS bit-index constants;
  - the FSM state typedef (IDLE, SETUP, ACCESS).
- Sub-module apb_slave_handshake contains the FSM, wcnt and address/error decode. It outputs wr_en, rd_en, reg_sel and err to the top level.
- Register file and timer core live in apb_timer_slave.

## Test plan
- **Reset values:** reset, then read all four offsets with WAIT_STATES=1 → each reads 0x0, PREADY high exactly 2 cycles after setup, PSLVERR=0.
- **One-shot:** write LOAD=5, then CTRL=0x5 → COUNT reads 5,4,…,0. EXPIRED=1 and irq=1 one cycle after COUNT=0. CTRL reads 0x4.
- **Auto-reload:** LOAD=3, CTRL=0x3 → EXPIRED sets every 4 cycles. W1C of STATUS in the expiry cycle leaves EXPIRED=1.
- **Errors:** write 0x1234 to 0x08, 0x10 and 0x02 → PSLVERR=1 each time, registers unchanged. A read of 0x10 returns 0.
- **Wait states and abort:** WAIT_STATES=3 write, PSEL dropped after 2 access cycles → no commit, PREADY never 1. Retry completes at cycle 5.
- **Reset mid-transfer:** assert PRESETn low during ACCESS of a LOAD write → PREADY=0 at once, LOAD=0 afterwards.

Source files
------------

// File: rtl/apb_timer_pkg.sv
// apb_timer_pkg: shared constants and types for the APB timer slave.
// Register offsets, CTRL/STATUS bit positions and handshake FSM states.
package apb_timer_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_LOAD   = 8'h04;
  localparam logic [7:0] OFF_COUNT  = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;

  localparam logic [1:0] SEL_CTRL   = 2'd0;
  localparam logic [1:0] SEL_LOAD   = 2'd1;
  localparam logic [1:0] SEL_COUNT  = 2'd2;
  localparam logic [1:0] SEL_STATUS = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_AUTO    = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int STAT_EXPIRED = 0;

  typedef logic [1:0] apb_state_t;

  localparam apb_state_t ST_IDLE   = 2'd0;
  localparam apb_state_t ST_SETUP  = 2'd1;
  localparam apb_state_t ST_ACCESS = 2'd2;

endpackage

// File: rtl/apb_timer_slave_if.sv
// apb_timer_slave_if: APB bus bundle between the master and the timer.
// The master drives the request side, the slave drives the response side.
interface apb_timer_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_slave_handshake.sv
// apb_slave_handshake: APB completer FSM with wait-state counter.
// Produces PREADY and the commit strobes plus address/error decode.
module apb_slave_handshake
  import apb_timer_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  output logic       pready,
  output logic       wr_en,
  output logic       rd_en,
  output logic [1:0] reg_sel,
  output logic       err
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  apb_state_t state_q, state_d, cur;
  logic [3:0] wcnt_q, wcnt_d;

  // SETUP is the cycle in which IDLE sees PSEL & !PENABLE
  assign cur = (state_q == ST_IDLE && psel && !penable)
             ? ST_SETUP : state_q;

  always_comb begin
    state_d = ST_IDLE;
    wcnt_d  = wcnt_q;
    unique case (1'b1)
      (cur == ST_SETUP): begin
        state_d = ST_ACCESS;
        wcnt_d  = WS;
      end
      (cur == ST_ACCESS): begin
        if (psel && !penable) begin
          state_d = ST_ACCESS;
        end else if (psel && wcnt_q != 4'd0) begin
          state_d = ST_ACCESS;
          wcnt_d  = wcnt_q - 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
      wcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign pready = (state_q == ST_ACCESS) && psel && penable
                && (wcnt_q == 4'd0);

  assign reg_sel = paddr[3:2];
  assign err     = (|paddr[1:0]) || (|paddr[7:4])
                || (pwrite && paddr[3:2] == SEL_COUNT);

  assign wr_en = pready && pwrite && !err;
  assign rd_en = pready && !pwrite && !err;

endmodule

// File: rtl/apb_timer_slave.sv
// apb_timer_slave: APB completer with a programmable down-counting timer.
// Holds CTRL/LOAD/COUNT/STATUS and drives a level interrupt on expiry.
module apb_timer_slave
  import apb_timer_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  apb_timer_slave_if.slave   bus,
  output logic               irq
);

  localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  logic                  pready, wr_en, rd_en, err;
  logic [1:0]            reg_sel;
  logic                  en_q, auto_q, ie_q, exp_q;
  logic [DATA_WIDTH-1:0] load_q, count_q, rdata;
  logic [DATA_WIDTH-1:0] wd;
  logic                  wr_ctrl, wr_load, wr_stat, expire;
  logic                  unused_addr;

  assign unused_addr = ^bus.PADDR[ADDR_WIDTH-1:8];

  apb_slave_handshake #(
    .WAIT_STATES (WAIT_STATES)
  ) u_hs (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .psel    (bus.PSEL),
    .penable (bus.PENABLE),
    .pwrite  (bus.PWRITE),
    .paddr   (bus.PADDR[7:0]),
    .pready  (pready),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .reg_sel (reg_sel),
    .err     (err)
  );

  assign wd      = bus.PWDATA;
  assign wr_ctrl = wr_en && reg_sel == SEL_CTRL;
  assign wr_load = wr_en && reg_sel == SEL_LOAD;
  assign wr_stat = wr_en && reg_sel == SEL_STATUS;
  assign expire  = en_q && count_q == '0;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      en_q    <= 1'b0;
      auto_q  <= 1'b0;
      ie_q    <= 1'b0;
      exp_q   <= 1'b0;
      load_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_ctrl) begin
        en_q   <= wd[CTRL_EN];
        auto_q <= wd[CTRL_AUTO];
        ie_q   <= wd[CTRL_IRQ_EN];
      end else if (expire && !auto_q) begin
        en_q <= 1'b0;
      end
      if (wr_load) begin
        load_q  <= wd;
        count_q <= wd;
      end else if (en_q) begin
        if (count_q != '0)
          count_q <= count_q - ONE;
        else if (auto_q)
          count_q <= load_q;
      end
      // hardware set wins over a same-cycle clear
      if (expire)
        exp_q <= 1'b1;
      else if (wr_stat && wd[STAT_EXPIRED])
        exp_q <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (reg_sel == SEL_CTRL):
        rdata = {{(DATA_WIDTH-3){1'b0}}, ie_q, auto_q, en_q};
      (reg_sel == SEL_LOAD):   rdata = load_q;
      (reg_sel == SEL_COUNT):  rdata = count_q;
      (reg_sel == SEL_STATUS):
        rdata = {{(DATA_WIDTH-1){1'b0}}, exp_q};
      default: rdata = '0;
    endcase
  end

  assign bus.PRDATA  = rd_en ? rdata : '0;
  assign bus.PREADY  = pready;
  assign bus.PSLVERR = pready && err;
  assign irq         = exp_q && ie_q;

endmodule

// File: tb/tb_apb_timer_slave.sv
// tb_apb_timer_slave: directed bench for the APB timer slave.
// Two instances: one-wait-state for the register map, three for abort/reset.
module tb_apb_timer_slave;
  import apb_timer_pkg::*;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic        use3 = 1'b0;
  logic        irq1, irq3;

  always #5 PCLK = ~PCLK;

  apb_timer_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b1 ();
  apb_timer_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b3 ();

  assign b1.PSEL    = psel & ~use3;
  assign b1.PENABLE = penable;
  assign b1.PWRITE  = pwrite;
  assign b1.PADDR   = paddr;
  assign b1.PWDATA  = pwdata;
  assign b3.PSEL    = psel & use3;
  assign b3.PENABLE = penable;
  assign b3.PWRITE  = pwrite;
  assign b3.PADDR   = paddr;
  assign b3.PWDATA  = pwdata;

  apb_timer_slave #(
    .ADDR_WIDTH (32), .DATA_WIDTH (32), .WAIT_STATES (1)
  ) u_dut1 (
    .PCLK (PCLK), .PRESETn (PRESETn), .bus (b1.slave), .irq (irq1)
  );

  apb_timer_slave #(
    .ADDR_WIDTH (32), .DATA_WIDTH (32), .WAIT_STATES (3)
  ) u_dut3 (
    .PCLK (PCLK), .PRESETn (PRESETn), .bus (b3.slave), .irq (irq3)
  );

  wire        pready  = use3 ? b3.PREADY  : b1.PREADY;
  wire        pslverr = use3 ? b3.PSLVERR : b1.PSLVERR;
  wire [31:0] prdata  = use3 ? b3.PRDATA  : b1.PRDATA;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // one full transfer; n = cycles from setup to the PREADY cycle
  task automatic apb(input logic w, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rd,
                     output logic er, output int n);
    bit got;
    got = 1'b0;
    n   = 0;
    rd  = '0;
    er  = 1'b0;
    @(posedge PCLK); #1;
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    @(posedge PCLK); #1;
    penable = 1'b1;
    for (int k = 0; k < 32; k++) begin
      n++;
      @(negedge PCLK);
      if (pready) begin
        got = 1'b1;
        break;
      end
      @(posedge PCLK); #1;
    end
    if (!got) begin
      checks++;
      fails++;
      $display("FAIL pready_timeout: addr 0x%08h never completed", a);
    end
    rd = prdata;
    er = pslverr;
    @(posedge PCLK); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr(input string nm, input logic [31:0] a,
                    input logic [31:0] d);
    logic [31:0] rd;
    logic er;
    int n;
    apb(1'b1, a, d, rd, er, n);
    check({nm, "_err"}, 32'(er), 32'd0);
  endtask

  task automatic rdchk(input string nm, input logic [31:0] a,
                       input logic [31:0] exp);
    logic [31:0] rd;
    logic er;
    int n;
    apb(1'b0, a, 32'h0, rd, er, n);
    check(nm, rd, exp);
  endtask

  task automatic poll_irq(input string nm, input bit on3,
                          input int exp_n);
    int n;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge PCLK);
      n++;
      if (on3 ? irq3 : irq1) break;
    end
    check(nm, 32'(n), 32'(exp_n));
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  vec_t tbl[20];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          n;
    bit          seen;

    tbl[0]  = '{1'b0, 32'h00, 32'h0,        32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h04, 32'h0,        32'h0,        1'b0};
    tbl[2]  = '{1'b0, 32'h08, 32'h0,        32'h0,        1'b0};
    tbl[3]  = '{1'b0, 32'h0C, 32'h0,        32'h0,        1'b0};
    tbl[4]  = '{1'b1, 32'h04, 32'hA5A50001, 32'h0,        1'b0};
    tbl[5]  = '{1'b0, 32'h04, 32'h0,        32'hA5A50001, 1'b0};
    tbl[6]  = '{1'b0, 32'h08, 32'h0,        32'hA5A50001, 1'b0};
    tbl[7]  = '{1'b1, 32'h08, 32'h1234,     32'h0,        1'b1};
    tbl[8]  = '{1'b1, 32'h10, 32'h1234,     32'h0,        1'b1};
    tbl[9]  = '{1'b1, 32'h02, 32'h1234,     32'h0,        1'b1};
    tbl[10] = '{1'b0, 32'h00, 32'h0,        32'h0,        1'b0};
    tbl[11] = '{1'b0, 32'h04, 32'h0,        32'hA5A50001, 1'b0};
    tbl[12] = '{1'b0, 32'h08, 32'h0,        32'hA5A50001, 1'b0};
    tbl[13] = '{1'b0, 32'h10, 32'h0,        32'h0,        1'b1};
    tbl[14] = '{1'b1, 32'h00, 32'hFFFFFFF8, 32'h0,        1'b0};
    tbl[15] = '{1'b0, 32'h00, 32'h0,        32'h0,        1'b0};
    tbl[16] = '{1'b0, 32'h104, 32'h0,       32'hA5A50001, 1'b0};
    tbl[17] = '{1'b1, 32'h40, 32'h1,        32'h0,        1'b1};
    tbl[18] = '{1'b0, 32'h0C, 32'h0,        32'h0,        1'b0};
    tbl[19] = '{1'b0, 32'h01, 32'h0,        32'h0,        1'b1};

    #2;
    check("rst_pready",  32'(pready),  32'd0);
    check("rst_pslverr", 32'(pslverr), 32'd0);
    check("rst_prdata",  prdata,       32'd0);
    check("rst_irq1",    32'(irq1),    32'd0);
    check("rst_irq3",    32'(irq3),    32'd0);
    @(posedge PCLK); @(posedge PCLK); #1;
    PRESETn = 1'b1;

    for (int i = 0; i < 20; i++) begin
      apb(tbl[i].w, tbl[i].a, tbl[i].d, rd, er, n);
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].er));
      check($sformatf("vec%0d_cycles", i), 32'(n), 32'd2);
    end

    // one-shot: COUNT frozen, then 5 -> 0 with irq and EN self-clear
    wr("os_load", 32'h04, 32'd5);
    rdchk("os_frozen", 32'h08, 32'd5);
    wr("os_ctrl", 32'h00, 32'h5);
    rdchk("os_count_mid", 32'h08, 32'd2);
    poll_irq("os_irq_delay", 1'b0, 3);
    rdchk("os_count_end", 32'h08, 32'd0);
    rdchk("os_status", 32'h0C, 32'd1);
    rdchk("os_ctrl_rd", 32'h00, 32'h4);
    wr("os_w1c", 32'h0C, 32'h1);
    @(negedge PCLK);
    check("os_irq_fall", 32'(irq1), 32'd0);
    rdchk("os_status_clr", 32'h0C, 32'd0);

    // auto-reload period 4; W1C in expiry cycle loses
    wr("ar_load", 32'h04, 32'd3);
    wr("ar_ctrl", 32'h00, 32'h7);
    wr("ar_w1c_hit", 32'h0C, 32'h1);
    @(negedge PCLK);
    check("ar_w1c_loses", 32'(irq1), 32'd1);
    @(posedge PCLK);
    wr("ar_w1c_ok", 32'h0C, 32'h1);
    poll_irq("ar_period", 1'b0, 4);

    // LOAD=0 with auto-reload re-sets EXPIRED every cycle
    wr("z_load", 32'h04, 32'd0);
    wr("z_w1c", 32'h0C, 32'h1);
    @(negedge PCLK);
    check("z_irq_stays", 32'(irq1), 32'd1);
    rdchk("z_count", 32'h08, 32'd0);
    wr("z_ctrl_off", 32'h00, 32'h0);

    // three wait states: abort after two access cycles
    use3 = 1'b1;
    seen = 1'b0;
    @(posedge PCLK); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h04; pwdata = 32'h55;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(negedge PCLK); seen |= pready;
    @(posedge PCLK); #1;
    @(negedge PCLK); seen |= pready;
    @(posedge PCLK); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge PCLK); seen |= pready;
    check("abort_no_ready", 32'(seen), 32'd0);
    apb(1'b0, 32'h04, 32'h0, rd, er, n);
    check("abort_no_commit", rd, 32'd0);
    check("ws3_rd_cycles", 32'(n), 32'd4);
    apb(1'b1, 32'h04, 32'h55, rd, er, n);
    check("ws3_retry_cycles", 32'(n), 32'd4);
    check("ws3_retry_err", 32'(er), 32'd0);
    rdchk("ws3_load", 32'h04, 32'h55);

    // reset during the PREADY cycle of a LOAD write
    seen = 1'b0;
    @(posedge PCLK); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h04; pwdata = 32'h77;
    @(posedge PCLK); #1;
    penable = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge PCLK);
      if (pready) begin
        seen = 1'b1;
        break;
      end
      @(posedge PCLK); #1;
    end
    check("mid_ready_seen", 32'(seen), 32'd1);
    #1 PRESETn = 1'b0;
    #1;
    check("mid_rst_pready", 32'(pready), 32'd0);
    check("mid_rst_prdata", prdata, 32'd0);
    @(posedge PCLK); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    rdchk("mid_rst_load", 32'h04, 32'd0);
    rdchk("mid_rst_count", 32'h08, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
